// File: rtl/pll_lock_ctrl_pkg.sv
// Shared definitions for the PLL lock sequencer: state encodings, default timing
// constants and width helpers used by the interface and the controller.
package pll_lock_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } pll_state_t;

    localparam int DEF_RST_CYC      = 10;
    localparam int DEF_LOCK_TIMEOUT = 50000;
    localparam int DEF_STABLE_CYC   = 1000;
    localparam int DEF_MAX_RETRY    = 3;

    // The counter only ever has to reach (limit - 1), so $clog2 of the largest limit suffices.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    function automatic int retry_width(input int max_retry);
        return (max_retry < 1) ? 1 : $clog2(max_retry + 1);
    endfunction

endpackage

// File: rtl/pll_lock_ctrl_if.sv
// Signal bundle between the lock sequencer (master) and the PLL / downstream reset
// consumers (slave).
interface pll_lock_ctrl_if
    import pll_lock_ctrl_pkg::*;
#(
    parameter int MAX_RETRY = DEF_MAX_RETRY
);
    localparam int RW = retry_width(MAX_RETRY);

    logic          locked;
    logic          pll_areset;
    logic          rst_n_out;
    logic          lock_err;
    logic [RW-1:0] retry_cnt;
    logic [7:0]    lost_cnt;

    modport master (
        input  locked,
        output pll_areset, rst_n_out, lock_err, retry_cnt, lost_cnt
    );

    modport slave (
        output locked,
        input  pll_areset, rst_n_out, lock_err, retry_cnt, lost_cnt
    );

endinterface

// File: rtl/pll_lock_ctrl_sync_2ff.sv
// Generic 1-bit two-flop synchroniser with asynchronous active-low reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL bring-up sequencer: pulses the PLL areset, waits for a stable lock, then releases
// the downstream reset; retries on timeout and latches a fault after MAX_RETRY failures.
module pll_lock_ctrl
    import pll_lock_ctrl_pkg::*;
#(
    parameter int RST_CYC      = DEF_RST_CYC,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYC   = DEF_STABLE_CYC,
    parameter int MAX_RETRY    = DEF_MAX_RETRY
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    pll_lock_ctrl_if.master bus
);

    localparam int CW = cnt_width(RST_CYC, LOCK_TIMEOUT, STABLE_CYC);
    localparam int RW = retry_width(MAX_RETRY);

    pll_state_t    state;
    pll_state_t    nxt_state;
    logic [CW-1:0] cnt;
    logic          locked_s;
    logic          timeout_hit;
    logic [RW-1:0] retry_inc;

    sync_2ff u_lock_sync (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .d     (bus.locked),
        .q     (locked_s)
    );

    assign retry_inc = bus.retry_cnt + RW'(1);

    // Lock is checked before the timeout so a lock arriving on the last wait cycle wins.
    always_comb begin
        nxt_state   = state;
        timeout_hit = 1'b0;
        case (state)
            ST_RESET: begin
                if (cnt == CW'(RST_CYC - 1)) nxt_state = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    nxt_state = ST_STABLE;
                end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    nxt_state   = (retry_inc == RW'(MAX_RETRY)) ? ST_FAIL : ST_RESET;
                end
            end
            ST_STABLE: begin
                if (!locked_s)                           nxt_state = ST_WAIT_LOCK;
                else if (cnt == CW'(STABLE_CYC - 1))     nxt_state = ST_RUN;
            end
            ST_RUN: begin
                if (!locked_s) nxt_state = ST_RESET;
            end
            ST_FAIL: nxt_state = ST_FAIL;
            default: nxt_state = ST_RESET;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state          <= ST_RESET;
            cnt            <= '0;
            bus.pll_areset <= 1'b1;
            bus.rst_n_out  <= 1'b0;
            bus.lock_err   <= 1'b0;
            bus.retry_cnt  <= '0;
            bus.lost_cnt   <= '0;
        end else begin
            state <= nxt_state;
            if (nxt_state != state || state == ST_RUN || state == ST_FAIL)
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);

            bus.pll_areset <= (nxt_state == ST_RESET) || (nxt_state == ST_FAIL);
            bus.rst_n_out  <= (nxt_state == ST_RUN);
            bus.lock_err   <= (nxt_state == ST_FAIL);

            if (timeout_hit)
                bus.retry_cnt <= retry_inc;
            else if (nxt_state == ST_RUN)
                bus.retry_cnt <= '0;

            if (state == ST_RUN && nxt_state == ST_RESET && bus.lost_cnt != 8'hFF)
                bus.lost_cnt <= bus.lost_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Self-checking bench for pll_lock_ctrl: a phase-level reference model checked every
// cycle, plus directed scenarios with hand-computed timing expectations.
module tb_pll_lock_ctrl;

    localparam int RST_CYC      = 4;
    localparam int LOCK_TIMEOUT = 100;
    localparam int STABLE_CYC   = 8;
    localparam int MAX_RETRY    = 2;

    logic sys_clk;
    logic sys_rst_n;
    int   tests_run;
    int   tests_failed;
    bit   check_en;

    pll_lock_ctrl_if #(.MAX_RETRY(MAX_RETRY)) bus ();

    pll_lock_ctrl #(
        .RST_CYC      (RST_CYC),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYC   (STABLE_CYC),
        .MAX_RETRY    (MAX_RETRY)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Reference model: phases with remaining/elapsed counts and a 2-deep history of locked.
    typedef enum {P_ARESET, P_WAIT, P_SETTLE, P_UP, P_DEAD} phase_t;

    typedef struct {
        phase_t phase;
        int     ar_left;
        int     wait_elapsed;
        int     good_run;
        int     retries;
        int     losses;
        logic   s1;
        logic   s2;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.phase        = P_ARESET;
        r.ar_left      = RST_CYC;
        r.wait_elapsed = 0;
        r.good_run     = 0;
        r.retries      = 0;
        r.losses       = 0;
        r.s1           = 1'b0;
        r.s2           = 1'b0;
        return r;
    endfunction

    function automatic model_t model_step(input model_t c, input logic lk);
        model_t n;
        logic   seen;
        n    = c;
        seen = c.s2;
        n.s2 = c.s1;
        n.s1 = lk;
        case (c.phase)
            P_ARESET: begin
                n.ar_left = c.ar_left - 1;
                if (n.ar_left == 0) begin
                    n.phase        = P_WAIT;
                    n.wait_elapsed = 0;
                end
            end
            P_WAIT: begin
                if (seen) begin
                    n.phase    = P_SETTLE;
                    n.good_run = 0;
                end else begin
                    n.wait_elapsed = c.wait_elapsed + 1;
                    if (n.wait_elapsed == LOCK_TIMEOUT) begin
                        n.retries = c.retries + 1;
                        if (n.retries == MAX_RETRY) begin
                            n.phase = P_DEAD;
                        end else begin
                            n.phase   = P_ARESET;
                            n.ar_left = RST_CYC;
                        end
                    end
                end
            end
            P_SETTLE: begin
                if (!seen) begin
                    n.phase        = P_WAIT;
                    n.wait_elapsed = 0;
                end else begin
                    n.good_run = c.good_run + 1;
                    if (n.good_run == STABLE_CYC) begin
                        n.phase   = P_UP;
                        n.retries = 0;
                    end
                end
            end
            P_UP: begin
                if (!seen) begin
                    n.phase   = P_ARESET;
                    n.ar_left = RST_CYC;
                    n.losses  = (c.losses < 255) ? c.losses + 1 : 255;
                end
            end
            default: n.phase = P_DEAD;
        endcase
        return n;
    endfunction

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) m <= model_reset();
        else            m <= model_step(m, bus.locked);
    end

    task automatic check_output(input string name, input int actual, input int expected);
        tests_run = tests_run + 1;
        if (actual != expected) begin
            tests_failed = tests_failed + 1;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge sys_clk) begin
        if (check_en) begin
            check_output("model pll_areset", int'(bus.pll_areset),
                         int'(m.phase == P_ARESET || m.phase == P_DEAD));
            check_output("model rst_n_out", int'(bus.rst_n_out), int'(m.phase == P_UP));
            check_output("model lock_err", int'(bus.lock_err), int'(m.phase == P_DEAD));
            check_output("model retry_cnt", int'(bus.retry_cnt), m.retries);
            check_output("model lost_cnt", int'(bus.lost_cnt), m.losses);
        end
    end

    function automatic logic sig_of(input int which);
        case (which)
            0:       return bus.pll_areset;
            1:       return bus.rst_n_out;
            default: return bus.lock_err;
        endcase
    endfunction

    // Counts negedges until the selected output reaches val; n = -1 if the bound expires.
    task automatic count_until(input int which, input logic val, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge sys_clk);
            if (sig_of(which) == val) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic apply_stimulus(input logic lk);
        bus.locked = lk;
    endtask

    task automatic apply_reset(input logic lk);
        @(negedge sys_clk);
        apply_stimulus(lk);
        sys_rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    initial begin
        int  n;
        bit  seen_up;
        tests_run    = 0;
        tests_failed = 0;
        check_en     = 1'b0;
        sys_rst_n    = 1'b1;
        bus.locked   = 1'b0;
        #3 sys_rst_n = 1'b0;
        #1 check_en  = 1'b1;

        // Reset values while sys_rst_n is held low
        @(negedge sys_clk);
        check_output("reset pll_areset", int'(bus.pll_areset), 1);
        check_output("reset rst_n_out", int'(bus.rst_n_out), 0);
        check_output("reset lock_err", int'(bus.lock_err), 0);
        check_output("reset retry_cnt", int'(bus.retry_cnt), 0);
        check_output("reset lost_cnt", int'(bus.lost_cnt), 0);

        // Normal bring-up: lock 20 cycles after areset falls
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        count_until(0, 1'b0, 20, n);
        check_output("bringup areset length", n, RST_CYC);
        repeat (20) @(negedge sys_clk);
        apply_stimulus(1'b1);
        count_until(1, 1'b1, 50, n);
        check_output("bringup lock to release", n, 2 + 1 + STABLE_CYC);
        check_output("bringup retry_cnt", int'(bus.retry_cnt), 0);
        check_output("bringup lock_err", int'(bus.lock_err), 0);

        // Single timeout, lock on second attempt
        apply_reset(1'b0);
        count_until(0, 1'b0, 20, n);
        check_output("timeout first areset", n, RST_CYC);
        count_until(0, 1'b1, 200, n);
        check_output("timeout wait length", n, LOCK_TIMEOUT);
        check_output("timeout retry_cnt", int'(bus.retry_cnt), 1);
        count_until(0, 1'b0, 20, n);
        check_output("timeout second areset", n, RST_CYC);
        apply_stimulus(1'b1);
        count_until(1, 1'b1, 50, n);
        check_output("timeout lock to release", n, 2 + 1 + STABLE_CYC);
        check_output("timeout retry cleared", int'(bus.retry_cnt), 0);

        // Hard fail with locked stuck low
        apply_reset(1'b0);
        count_until(2, 1'b1, 400, n);
        check_output("fail entry time", n, 2 * LOCK_TIMEOUT + 2 * RST_CYC);
        repeat (1000) @(negedge sys_clk);
        check_output("fail lock_err held", int'(bus.lock_err), 1);
        check_output("fail pll_areset held", int'(bus.pll_areset), 1);
        check_output("fail rst_n_out held", int'(bus.rst_n_out), 0);
        check_output("fail retry_cnt", int'(bus.retry_cnt), MAX_RETRY);
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        check_output("fail cleared lock_err", int'(bus.lock_err), 0);
        check_output("fail cleared retry_cnt", int'(bus.retry_cnt), 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // Unstable lock: high 5, low 1, repeatedly
        apply_reset(1'b0);
        seen_up = 1'b0;
        for (int k = 0; k < 50; k++) begin
            apply_stimulus(1'b1);
            repeat (5) begin
                @(negedge sys_clk);
                if (bus.rst_n_out) seen_up = 1'b1;
            end
            apply_stimulus(1'b0);
            @(negedge sys_clk);
            if (bus.rst_n_out) seen_up = 1'b1;
        end
        check_output("unstable never released", int'(seen_up), 0);
        check_output("unstable retry_cnt", int'(bus.retry_cnt), 0);

        // Lock loss in RUN
        apply_reset(1'b1);
        count_until(1, 1'b1, 50, n);
        check_output("loss initial release", int'(n > 0), 1);
        apply_stimulus(1'b0);
        count_until(1, 1'b0, 10, n);
        check_output("loss release drop", n, 3);
        check_output("loss lost_cnt", int'(bus.lost_cnt), 1);
        repeat (10 - n) @(negedge sys_clk);
        apply_stimulus(1'b1);
        count_until(1, 1'b1, 60, n);
        check_output("loss rerun release", int'(n > 0), 1);
        for (int k = 0; k < 255; k++) begin
            apply_stimulus(1'b0);
            repeat (3) @(negedge sys_clk);
            apply_stimulus(1'b1);
            count_until(1, 1'b1, 60, n);
            if (n < 0) check_output("loss loop release", n, 1);
        end
        check_output("loss saturated", int'(bus.lost_cnt), 255);

        // Async reset in the middle of STABLE
        apply_stimulus(1'b0);
        count_until(1, 1'b0, 10, n);
        repeat (2) @(negedge sys_clk);
        apply_stimulus(1'b1);
        count_until(0, 1'b0, 50, n);
        repeat (3) @(negedge sys_clk);
        check_output("async pre pll_areset", int'(bus.pll_areset), 0);
        #2 sys_rst_n = 1'b0;
        #1;
        check_output("async pll_areset", int'(bus.pll_areset), 1);
        check_output("async rst_n_out", int'(bus.rst_n_out), 0);
        check_output("async lost_cnt", int'(bus.lost_cnt), 0);
        check_output("async lock_err", int'(bus.lock_err), 0);
        check_output("async retry_cnt", int'(bus.retry_cnt), 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
